// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default bus widths and the arbiter state encoding.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ABORT
    } wb_state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Stall counter for a Wishbone slave port; o_expire flags the last tolerated stalled cycle.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_stall,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] r_cnt;

    // With TIMEOUT == 0 the counter still runs but can never expire.
    assign o_expire = (TIMEOUT > 0) && i_stall && (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_stall || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone classic arbiter: round-robin per bus cycle, stuck-slave timeout returns err.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int ADR_W   = WB_ADR_W,
    parameter int DAT_W   = WB_DAT_W,
    parameter int TIMEOUT = 1024
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [ADR_W-1:0]   m0_adr_i,
    input  logic [DAT_W-1:0]   m0_dat_i,
    output logic [DAT_W-1:0]   m0_dat_o,
    input  logic [DAT_W/8-1:0] m0_sel_i,
    input  logic               m0_we_i,
    input  logic               m0_stb_i,
    input  logic               m0_cyc_i,
    output logic               m0_ack_o,
    output logic               m0_err_o,
    input  logic [ADR_W-1:0]   m1_adr_i,
    input  logic [DAT_W-1:0]   m1_dat_i,
    output logic [DAT_W-1:0]   m1_dat_o,
    input  logic [DAT_W/8-1:0] m1_sel_i,
    input  logic               m1_we_i,
    input  logic               m1_stb_i,
    input  logic               m1_cyc_i,
    output logic               m1_ack_o,
    output logic               m1_err_o,
    output logic [ADR_W-1:0]   s_adr_o,
    output logic [DAT_W-1:0]   s_dat_o,
    output logic [DAT_W/8-1:0] s_sel_o,
    output logic               s_we_o,
    output logic               s_stb_o,
    output logic               s_cyc_o,
    input  logic [DAT_W-1:0]   s_dat_i,
    input  logic               s_ack_i,
    input  logic               s_err_i
);

    wb_state_e r_state;
    logic      r_owner;
    logic      r_last;
    logic      r_to_err;

    logic [1:0] w_req;
    logic       w_gnt;
    logic       w_own_cyc;
    logic       w_busy;
    logic       w_stall;
    logic       w_expire;

    assign w_req     = {m1_cyc_i, m0_cyc_i};
    // A lone requester wins outright; on contention the master that did not go last wins.
    assign w_gnt     = (w_req == 2'b11) ? ~r_last : w_req[1];
    assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;
    assign w_busy    = (r_state == ST_BUSY);
    assign w_stall   = s_stb_o && !s_ack_i && !s_err_i;

    wb_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_stall (w_stall),
        .o_expire(w_expire)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_to_err <= 1'b0;
        end else begin
            r_to_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req != 2'b00) begin
                        r_state <= ST_BUSY;
                        r_owner <= w_gnt;
                        r_last  <= w_gnt;
                    end
                end
                ST_BUSY: begin
                    if (!w_own_cyc) begin
                        r_state <= ST_IDLE;
                    end else if (w_expire) begin
                        r_state  <= ST_ABORT;
                        r_to_err <= 1'b1;
                    end
                end
                ST_ABORT: begin
                    if (!w_own_cyc) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_err_o = 1'b0;
        if (r_state != ST_IDLE) begin
            s_adr_o = r_owner ? m1_adr_i : m0_adr_i;
            s_dat_o = r_owner ? m1_dat_i : m0_dat_i;
            s_sel_o = r_owner ? m1_sel_i : m0_sel_i;
            s_we_o  = r_owner ? m1_we_i  : m0_we_i;
        end
        if (w_busy) begin
            s_stb_o = r_owner ? m1_stb_i : m0_stb_i;
            s_cyc_o = r_owner ? m1_cyc_i : m0_cyc_i;
        end
        // Slave responses reach only the owner, and only while BUSY; ABORT drops late ones.
        if (r_owner) begin
            m1_dat_o = w_busy ? s_dat_i : '0;
            m1_ack_o = w_busy && s_ack_i;
            m1_err_o = (w_busy && s_err_i) || r_to_err;
        end else begin
            m0_dat_o = w_busy ? s_dat_i : '0;
            m0_ack_o = w_busy && s_ack_i;
            m0_err_o = (w_busy && s_err_i) || r_to_err;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: cycle-level ownership model plus hand-computed spot checks.
module tb_wb_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_stb [2];
    logic        m_cyc [2];
    logic [31:0] s_dat = '0;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;

    logic [31:0] dat_o0, dat_o1, s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        ack_o0, ack_o1, err_o0, err_o1, s_we_o, s_stb_o, s_cyc_o;

    int checks = 0;
    int failures = 0;

    // Model: mo = owning master (-1 none), ma = cycle aborted, mstall = consecutive stalled cycles.
    int mo = -1;
    int mlast = 1;
    int mstall = 0;
    bit ma = 1'b0;
    bit merrp = 1'b0;

    always #5 clk = ~clk;

    wb_arbiter #(.ADR_W(32), .DAT_W(32), .TIMEOUT(TO)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(dat_o0), .m0_sel_i(m_sel[0]),
        .m0_we_i(m_we[0]), .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]), .m0_ack_o(ack_o0), .m0_err_o(err_o0),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(dat_o1), .m1_sel_i(m_sel[1]),
        .m1_we_i(m_we[1]), .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]), .m1_ack_o(ack_o1), .m1_err_o(err_o1),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[k] = cyc;
        m_stb[k] = stb;
        m_we[k]  = we;
        m_adr[k] = adr;
        m_dat[k] = dat;
        m_sel[k] = cyc ? ((k == 1) ? 4'h3 : 4'hF) : 4'h0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mo = -1; ma = 1'b0; mlast = 1; mstall = 0; merrp = 1'b0;
        end else begin
            merrp = 1'b0;
            if (mo < 0) begin
                if (m_cyc[0] && m_cyc[1]) mo = 1 - mlast;
                else if (m_cyc[1])        mo = 1;
                else if (m_cyc[0])        mo = 0;
                if (mo >= 0) mlast = mo;
                mstall = 0;
            end else if (!m_cyc[mo]) begin
                mo = -1; ma = 1'b0; mstall = 0;
            end else if (!ma) begin
                if (m_stb[mo] && !s_ack && !s_err) begin
                    mstall++;
                    if (mstall == TO) begin
                        ma = 1'b1; merrp = 1'b1; mstall = 0;
                    end
                end else begin
                    mstall = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit          live;
        bit          own;
        logic [31:0] e_adr, e_dat;
        logic [3:0]  e_sel;
        logic        e_we;
        own   = (mo >= 0);
        live  = own && !ma;
        e_adr = own ? m_adr[mo] : 32'h0;
        e_dat = own ? m_dat[mo] : 32'h0;
        e_sel = own ? m_sel[mo] : 4'h0;
        e_we  = own ? m_we[mo]  : 1'b0;
        chk("cyc_s_adr", s_adr_o, e_adr);
        chk("cyc_s_dat", s_dat_o, e_dat);
        chk("cyc_s_sel", {28'h0, s_sel_o}, {28'h0, e_sel});
        chk("cyc_s_we",  {31'h0, s_we_o},  {31'h0, e_we});
        chk("cyc_s_cyc", {31'h0, s_cyc_o}, {31'h0, live && m_cyc[mo]});
        chk("cyc_s_stb", {31'h0, s_stb_o}, {31'h0, live && m_stb[mo]});
        chk("cyc_m0_ack", {31'h0, ack_o0}, {31'h0, live && mo == 0 && s_ack});
        chk("cyc_m1_ack", {31'h0, ack_o1}, {31'h0, live && mo == 1 && s_ack});
        chk("cyc_m0_err", {31'h0, err_o0}, {31'h0, mo == 0 && ((live && s_err) || merrp)});
        chk("cyc_m1_err", {31'h0, err_o1}, {31'h0, mo == 1 && ((live && s_err) || merrp)});
        chk("cyc_m0_dat", dat_o0, (live && mo == 0) ? s_dat : 32'h0);
        chk("cyc_m1_dat", dat_o1, (live && mo == 1) ? s_dat : 32'h0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_s_cyc", {31'h0, s_cyc_o}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single master M1 write: granted one cycle after request, ack to M1 only.
        set_m(1, 1, 1, 1, 32'h1000, 32'hDEADBEEF);
        #1 chk("t2_latency", {31'h0, s_cyc_o}, 32'h0);
        tick();
        chk("t2_s_cyc", {31'h0, s_cyc_o}, 32'h1);
        chk("t2_s_adr", s_adr_o, 32'h1000);
        chk("t2_s_dat", s_dat_o, 32'hDEADBEEF);
        s_ack = 1'b1;
        #1 chk("t2_m1_ack", {31'h0, ack_o1}, 32'h1);
        chk("t2_m0_ack", {31'h0, ack_o0}, 32'h0);
        tick();
        set_m(1, 0, 0, 0, 0, 0);
        s_ack = 1'b0;
        tick();
        chk("t2_idle", {31'h0, s_cyc_o}, 32'h0);

        // Reset mid-cycle while M0 owns with stb high.
        set_m(0, 1, 1, 0, 32'h40, 32'h0);
        tick();
        chk("t1_own", {31'h0, s_cyc_o}, 32'h1);
        s_ack = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("t1_s_cyc", {31'h0, s_cyc_o}, 32'h0);
        chk("t1_s_stb", {31'h0, s_stb_o}, 32'h0);
        chk("t1_m0_ack", {31'h0, ack_o0}, 32'h0);
        chk("t1_s_adr", s_adr_o, 32'h0);
        set_m(0, 0, 0, 0, 0, 0);
        s_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t1_idle", {31'h0, s_cyc_o}, 32'h0);

        // Contention from reset: M0, then M1, then M0 again.
        set_m(0, 1, 1, 1, 32'hA0, 32'h11);
        set_m(1, 1, 1, 1, 32'hB0, 32'h22);
        tick();
        chk("t3_first_m0", s_adr_o, 32'hA0);
        s_ack = 1'b1;
        tick();
        set_m(0, 0, 0, 0, 0, 0);
        s_ack = 1'b0;
        tick();
        chk("t3_gap", {31'h0, s_cyc_o}, 32'h0);
        tick();
        chk("t3_then_m1", s_adr_o, 32'hB0);
        s_ack = 1'b1;
        #1 chk("t3_m1_ack", {31'h0, ack_o1}, 32'h1);
        chk("t3_m0_noack", {31'h0, ack_o0}, 32'h0);
        tick();
        set_m(1, 0, 0, 0, 0, 0);
        set_m(0, 1, 1, 1, 32'hA4, 32'h33);
        s_ack = 1'b0;
        tick();
        set_m(1, 1, 1, 1, 32'hB4, 32'h44);
        tick();
        chk("t3_again_m0", s_adr_o, 32'hA4);
        s_ack = 1'b1;
        tick();
        set_m(0, 0, 0, 0, 0, 0);
        s_ack = 1'b0;
        tick();
        tick();
        chk("t4_m1_owns", s_adr_o, 32'hB4);

        // M1 holds cyc for 4 beats while M0 waits.
        set_m(0, 1, 1, 0, 32'hC0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            m_adr[1] = 32'h2000 + 32'(4 * i);
            s_ack = 1'b1;
            #1 chk("t4_beat_adr", s_adr_o, 32'h2000 + 32'(4 * i));
            chk("t4_beat_m1_ack", {31'h0, ack_o1}, 32'h1);
            chk("t4_beat_m0_ack", {31'h0, ack_o0}, 32'h0);
            tick();
        end
        set_m(1, 0, 0, 0, 0, 0);
        s_ack = 1'b0;
        tick();
        chk("t4_gap", {31'h0, s_cyc_o}, 32'h0);
        tick();
        chk("t4_m0_after", s_adr_o, 32'hC0);

        // Read data goes to the owner only.
        set_m(1, 1, 1, 0, 32'hD0, 32'h0);
        s_dat = 32'h12345678;
        s_ack = 1'b1;
        #1 chk("t6_m0_dat", dat_o0, 32'h12345678);
        chk("t6_m1_dat", dat_o1, 32'h0);
        tick();
        set_m(0, 0, 0, 0, 0, 0);
        s_ack = 1'b0;
        s_dat = 32'h0;
        tick();
        tick();

        // Ack on the 8th stalled cycle beats the timeout.
        chk("tb_m1_owns", s_adr_o, 32'hD0);
        repeat (7) tick();
        s_ack = 1'b1;
        #1 chk("tb_ack_wins_ack", {31'h0, ack_o1}, 32'h1);
        tick();
        s_ack = 1'b0;
        chk("tb_ack_wins_err", {31'h0, err_o1}, 32'h0);
        chk("tb_ack_wins_cyc", {31'h0, s_cyc_o}, 32'h1);
        set_m(1, 0, 0, 0, 0, 0);
        tick();

        // Timeout: 8 stalled cycles then err for one cycle and the bus is released.
        set_m(0, 1, 1, 0, 32'hE0, 32'h0);
        tick();
        tick();
        repeat (6) tick();
        chk("t5_cyc8_cyc", {31'h0, s_cyc_o}, 32'h1);
        chk("t5_cyc8_err", {31'h0, err_o0}, 32'h0);
        tick();
        chk("t5_err", {31'h0, err_o0}, 32'h1);
        chk("t5_drop", {31'h0, s_cyc_o}, 32'h0);
        s_ack = 1'b1;
        #1 chk("t5_late_ack", {31'h0, ack_o0}, 32'h0);
        tick();
        chk("t5_err_pulse", {31'h0, err_o0}, 32'h0);
        chk("t5_abort_cyc", {31'h0, s_cyc_o}, 32'h0);
        set_m(0, 0, 0, 0, 0, 0);
        s_ack = 1'b0;
        tick();
        chk("t5_idle", {31'h0, s_cyc_o}, 32'h0);

        // Simultaneous ack and err both reach the owner.
        set_m(1, 1, 1, 1, 32'hF0, 32'h55);
        tick();
        s_ack = 1'b1;
        s_err = 1'b1;
        #1 chk("tx_ack", {31'h0, ack_o1}, 32'h1);
        chk("tx_err", {31'h0, err_o1}, 32'h1);
        tick();
        set_m(1, 0, 0, 0, 0, 0);
        s_ack = 1'b0;
        s_err = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
